// File: rtl/quic_golomb_dec_stream_if.sv
// Handshake bundle between the bitstream fetcher / reconstruction FSM and the
// streaming Golomb decoder: word input, decode command, symbol output.
interface quic_golomb_dec_stream_if #(
    parameter int BPC    = 8,
    parameter int CODE_W = 4
);
    logic              word_valid;
    logic              word_ready;
    logic [31:0]       word_data;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CODE_W-1:0] cmd_bestcode;
    logic [31:0]       cmd_ngr_codewords;
    logic [5:0]        cmd_ngr_cwlen;
    logic [31:0]       cmd_ngr_prefixmask;
    logic [4:0]        cmd_ngr_suffixlen;

    logic              sym_valid;
    logic              sym_ready;
    logic [BPC-1:0]    sym_value;
    logic [5:0]        sym_len;
    logic              sym_error;

    modport master (
        output word_valid, word_data,
        output cmd_valid, cmd_bestcode, cmd_ngr_codewords, cmd_ngr_cwlen,
               cmd_ngr_prefixmask, cmd_ngr_suffixlen,
        output sym_ready,
        input  word_ready, cmd_ready, sym_valid, sym_value, sym_len, sym_error
    );

    modport slave (
        input  word_valid, word_data,
        input  cmd_valid, cmd_bestcode, cmd_ngr_codewords, cmd_ngr_cwlen,
               cmd_ngr_prefixmask, cmd_ngr_suffixlen,
        input  sym_ready,
        output word_ready, cmd_ready, sym_valid, sym_value, sym_len, sym_error
    );
endinterface

// File: rtl/quic_golomb_dec_stream.sv
// Streaming QUIC Golomb symbol decoder: owns a 64-bit MSB-aligned bit buffer,
// decodes one GR / non-GR codeword per command and consumes its bits.
module quic_golomb_dec_stream #(
    parameter int BPC    = 8,
    parameter int CODE_W = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            flush,
    quic_golomb_dec_stream_if.slave         bus
);
    typedef enum logic [1:0] {IDLE, DECODE, OUT} state_t;

    state_t            state_q;
    logic [63:0]       buf_q, buf_d;
    logic [6:0]        lvl_q, lvl_d;
    logic [CODE_W-1:0] bc_q;
    logic [31:0]       cw_q;
    logic [5:0]        cwlen_q;
    logic [31:0]       pm_q;
    logic [4:0]        sl_q;
    logic              cmd_ready_q;
    logic              sym_valid_q;
    logic [BPC-1:0]    sym_value_q;
    logic [5:0]        sym_len_q;
    logic              sym_error_q;

    logic [31:0]       win;
    logic [5:0]        lz;
    logic [6:0]        gr_len;
    logic [BPC-1:0]    dec_val;
    logic [5:0]        dec_len;
    logic              dec_err;
    logic [5:0]        cons_len;
    logic              word_acc;

    assign win            = buf_q[63:32];
    assign bus.word_ready = (lvl_q <= 7'd32);
    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.sym_valid  = sym_valid_q;
    assign bus.sym_value  = sym_value_q;
    assign bus.sym_len    = sym_len_q;
    assign bus.sym_error  = sym_error_q;

    always_comb begin
        lz = 6'd32;
        for (int i = 0; i < 32; i++)
            if (win[i]) lz = 6'(31 - i);
    end

    // GR codes win whenever the window exceeds the non-GR prefix mask
    always_comb begin
        logic [31:0] v;
        v       = 32'd0;
        dec_len = 6'd0;
        dec_err = 1'b0;
        gr_len  = 7'({1'b0, lz}) + 7'(bc_q) + 7'd1;
        if (win > pm_q) begin
            if (gr_len > 7'd32) begin
                dec_err = 1'b1;
            end else begin
                dec_len = gr_len[5:0];
                v = (32'(lz) << bc_q) |
                    ((win >> (7'd32 - gr_len)) & ((32'd1 << bc_q) - 32'd1));
            end
        end else if (cwlen_q == 6'd0 || cwlen_q > 6'd32) begin
            dec_err = 1'b1;
        end else begin
            dec_len = cwlen_q;
            v = cw_q + ((win >> (7'd32 - 7'(cwlen_q))) & ((32'd1 << sl_q) - 32'd1));
        end
        dec_val = v[BPC-1:0];
    end

    // Consume first, then append the incoming word at the post-consume level
    always_comb begin
        word_acc = bus.word_valid && bus.word_ready;
        cons_len = (state_q == DECODE && lvl_q >= 7'd32 && !dec_err) ? dec_len : 6'd0;
        buf_d    = buf_q << cons_len;
        lvl_d    = lvl_q - 7'(cons_len);
        if (word_acc) begin
            buf_d = buf_d | ({bus.word_data, 32'd0} >> lvl_d);
            lvl_d = lvl_d + 7'd32;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            buf_q       <= 64'd0;
            lvl_q       <= 7'd0;
            bc_q        <= '0;
            cw_q        <= 32'd0;
            cwlen_q     <= 6'd0;
            pm_q        <= 32'd0;
            sl_q        <= 5'd0;
            cmd_ready_q <= 1'b0;
            sym_valid_q <= 1'b0;
            sym_value_q <= '0;
            sym_len_q   <= 6'd0;
            sym_error_q <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            buf_q       <= 64'd0;
            lvl_q       <= 7'd0;
            cmd_ready_q <= 1'b1;
            sym_valid_q <= 1'b0;
            sym_value_q <= '0;
            sym_len_q   <= 6'd0;
            sym_error_q <= 1'b0;
        end else begin
            buf_q <= buf_d;
            lvl_q <= lvl_d;
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        bc_q        <= bus.cmd_bestcode;
                        cw_q        <= bus.cmd_ngr_codewords;
                        cwlen_q     <= bus.cmd_ngr_cwlen;
                        pm_q        <= bus.cmd_ngr_prefixmask;
                        sl_q        <= bus.cmd_ngr_suffixlen;
                        cmd_ready_q <= 1'b0;
                        state_q     <= DECODE;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                DECODE: begin
                    if (lvl_q >= 7'd32) begin
                        sym_value_q <= dec_val;
                        sym_len_q   <= dec_len;
                        sym_error_q <= dec_err;
                        sym_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                OUT: begin
                    if (bus.sym_ready) begin
                        sym_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_quic_golomb_dec_stream.sv
// Directed bench for quic_golomb_dec_stream: expected symbols are queued when a
// command is issued and checked when the symbol handshake completes.
module tb_quic_golomb_dec_stream;
    localparam int BPC    = 8;
    localparam int CODE_W = 4;

    typedef struct packed {
        logic [BPC-1:0] v;
        logic [5:0]     l;
        logic           e;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    quic_golomb_dec_stream_if #(.BPC(BPC), .CODE_W(CODE_W)) bus ();
    quic_golomb_dec_stream #(.BPC(BPC), .CODE_W(CODE_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        int t = 0;
        bus.word_valid = 1'b1;
        bus.word_data  = w;
        while (!bus.word_ready && t < 50) begin tick(); t++; end
        chk("word_ready_wait", bus.word_ready, 1);
        tick();
        bus.word_valid = 1'b0;
        bus.word_data  = 32'd0;
    endtask

    task automatic send_cmd(input logic [CODE_W-1:0] bc, input logic [31:0] cw,
                            input logic [5:0] cwlen, input logic [31:0] pm,
                            input logic [4:0] sl, input exp_t e, input bit keep);
        int t = 0;
        bus.cmd_valid          = 1'b1;
        bus.cmd_bestcode       = bc;
        bus.cmd_ngr_codewords  = cw;
        bus.cmd_ngr_cwlen      = cwlen;
        bus.cmd_ngr_prefixmask = pm;
        bus.cmd_ngr_suffixlen  = sl;
        while (!bus.cmd_ready && t < 50) begin tick(); t++; end
        chk("cmd_ready_wait", bus.cmd_ready, 1);
        if (keep) sb.push_back(e);
        tick();
        bus.cmd_valid          = 1'b0;
        bus.cmd_ngr_codewords  = 32'hFFFF_FFFF;
        bus.cmd_ngr_prefixmask = 32'hFFFF_FFFF;
    endtask

    task automatic get_sym(input string tag);
        int   t = 0;
        exp_t e;
        while (!bus.sym_valid && t < 50) begin tick(); t++; end
        chk({tag, "_valid"}, bus.sym_valid, 1);
        chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_value"}, bus.sym_value, e.v);
            chk({tag, "_len"},   bus.sym_len,   e.l);
            chk({tag, "_error"}, bus.sym_error, e.e);
        end
        bus.sym_ready = 1'b1;
        tick();
        bus.sym_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.word_valid = 1'b0;
        bus.word_data  = 32'd0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_bestcode = '0;
        bus.cmd_ngr_codewords  = 32'd0;
        bus.cmd_ngr_cwlen      = 6'd0;
        bus.cmd_ngr_prefixmask = 32'd0;
        bus.cmd_ngr_suffixlen  = 5'd0;
        bus.sym_ready  = 1'b0;

        // reset values
        #12;
        chk("rst_sym_valid", bus.sym_valid, 0);
        chk("rst_word_ready", bus.word_ready, 1);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_sym_value", bus.sym_value, 0);
        chk("rst_sym_len", bus.sym_len, 0);
        chk("rst_sym_error", bus.sym_error, 0);
        #10 reset_n = 1'b1;
        tick();
        chk("idle_cmd_ready", bus.cmd_ready, 1);

        // GR decode: lz=2, bc=2 -> value 10, len 5
        push_word(32'h3000_0000);
        push_word(32'h0000_0000);
        chk("gr_lvl_full", dut.lvl_q, 64);
        chk("gr_word_ready_full", bus.word_ready, 0);
        send_cmd(4'd2, 32'd0, 6'd0, 32'h0000_FFFF, 5'd0, '{v: 8'd10, l: 6'd5, e: 1'b0}, 1'b1);
        get_sym("gr");
        chk("gr_lvl_after", dut.lvl_q, 59);

        // NGR decode with 5 cycles of backpressure
        do_flush();
        push_word(32'h0000_1234);
        push_word(32'h0000_0000);
        send_cmd(4'd0, 32'd100, 6'd20, 32'h0000_FFFF, 5'd4, '{v: 8'd101, l: 6'd20, e: 1'b0}, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", bus.sym_valid, 1);
            chk("bp_value", bus.sym_value, 101);
            chk("bp_len", bus.sym_len, 20);
            tick();
        end
        get_sym("ngr");
        chk("ngr_lvl_after", dut.lvl_q, 44);

        // GR overflow: lz=17, bc=15 -> len 33 is illegal
        do_flush();
        push_word(32'h0000_4000);
        push_word(32'h0000_0000);
        send_cmd(4'd15, 32'd0, 6'd0, 32'h0000_0000, 5'd0, '{v: 8'd0, l: 6'd0, e: 1'b1}, 1'b1);
        get_sym("err_gr");
        chk("err_gr_lvl", dut.lvl_q, 64);
        // NGR with cwlen 0 on the same window
        send_cmd(4'd0, 32'd5, 6'd0, 32'hFFFF_FFFF, 5'd3, '{v: 8'd0, l: 6'd0, e: 1'b1}, 1'b1);
        get_sym("err_ngr");
        chk("err_ngr_lvl", dut.lvl_q, 64);

        // Overlap: consume 24 to reach level 40, then a 12-bit GR code with a word pending
        do_flush();
        push_word(32'h1234_5600);
        push_word(32'hA000_0000);
        send_cmd(4'd0, 32'd7, 6'd24, 32'hFFFF_FFFF, 5'd0, '{v: 8'd7, l: 6'd24, e: 1'b0}, 1'b1);
        get_sym("ov_a");
        chk("ov_lvl40", dut.lvl_q, 40);
        bus.word_valid = 1'b1;
        bus.word_data  = 32'hDEAD_BEEF;
        send_cmd(4'd3, 32'd0, 6'd0, 32'h0000_0000, 5'd0, '{v: 8'd66, l: 6'd12, e: 1'b0}, 1'b1);
        chk("ov_decode_word_ready", bus.word_ready, 0);
        tick();
        chk("ov_lvl28", dut.lvl_q, 28);
        chk("ov_word_ready28", bus.word_ready, 1);
        tick();
        bus.word_valid = 1'b0;
        chk("ov_lvl60", dut.lvl_q, 60);
        get_sym("ov_b");

        // Starvation: command first, word 10 cycles later
        do_flush();
        send_cmd(4'd2, 32'd0, 6'd0, 32'h0000_FFFF, 5'd0, '{v: 8'd10, l: 6'd5, e: 1'b0}, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("starve_valid", bus.sym_valid, 0);
            chk("starve_word_ready", bus.word_ready, 1);
            tick();
        end
        push_word(32'h3000_0000);
        chk("starve_lvl32", dut.lvl_q, 32);
        chk("starve_valid_at32", bus.sym_valid, 0);
        tick();
        chk("starve_valid_rise", bus.sym_valid, 1);
        get_sym("starve");

        // Flush while a symbol is presented
        do_flush();
        push_word(32'h3000_0000);
        push_word(32'h0000_0000);
        send_cmd(4'd2, 32'd0, 6'd0, 32'h0000_FFFF, 5'd0, '{v: 8'd0, l: 6'd0, e: 1'b0}, 1'b0);
        tick();
        chk("fl_out_valid", bus.sym_valid, 1);
        do_flush();
        chk("fl_valid", bus.sym_valid, 0);
        chk("fl_lvl", dut.lvl_q, 0);
        chk("fl_cmd_ready", bus.cmd_ready, 1);

        // Asynchronous reset in the middle of DECODE
        push_word(32'h3000_0000);
        send_cmd(4'd2, 32'd0, 6'd0, 32'h0000_FFFF, 5'd0, '{v: 8'd0, l: 6'd0, e: 1'b0}, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_sym_valid", bus.sym_valid, 0);
        chk("ar_cmd_ready", bus.cmd_ready, 0);
        chk("ar_word_ready", bus.word_ready, 1);
        chk("ar_sym_len", bus.sym_len, 0);
        chk("ar_lvl", dut.lvl_q, 0);
        #10 reset_n = 1'b1;
        tick();
        tick();
        chk("ar_cmd_ready_back", bus.cmd_ready, 1);

        chk("sb_drained", 64'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/quic_golomb_dec_stream.md
Name: quic_golomb_dec_stream

Overview:
- Sequential, parametrised successor to the QUIC per-channel Golomb symbol decoder.
- Owns its own bit buffer and is fed 32-bit bitstream words through a valid/ready handshake.
- Accepts one decode command per symbol; the command carries the bestcode and the non-GR table entry for that code.
- Returns the decoded symbol and codeword length through an output valid/ready handshake, and removes the consumed bits itself. Sits between the bitstream fetcher and the R/G/B reconstruction FSM.

Parameters:
BPC, 8, bits per channel of the decoded symbol (1..16); value output is truncated to BPC bits.
CODE_W, 4, width of bestcode field (bestcode range 0..2^CODE_W-1, max 15).

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear: empties buffer, drops command/symbol, returns to IDLE
word_valid  input  1  bitstream word available
word_ready  output  1  block accepts word this cycle
word_data  input  32  bitstream word, MSB first
cmd_valid  input  1  decode request
cmd_ready  output  1  request accepted
cmd_bestcode  input  CODE_W  Golomb-Rice parameter
cmd_ngr_codewords  input  32  nGRcodewords for bestcode
cmd_ngr_cwlen  input  6  notGRcwlen for bestcode
cmd_ngr_prefixmask  input  32  notGRprefixmask for bestcode
cmd_ngr_suffixlen  input  5  notGRsuffixlen for bestcode
sym_valid  output  1  decoded symbol valid
sym_ready  input  1  consumer takes symbol
sym_value  output  BPC  decoded value
sym_len  output  6  bits consumed by this codeword
sym_error  output  1  illegal codeword; no bits consumed

Behaviour:
- Clock is clk. Reset is reset_n: asynchronous, active-low.
- Reset values: all outputs 0 except word_ready=1. State IDLE, buffer level 0, buffer contents 0.
- Buffer: 64-bit register, MSB-aligned, plus level counter 0..64.
  - word_ready = (level <= 32), combinational from registered level.
  - A word is accepted on word_valid&&word_ready and is appended immediately below the current valid bits.
- Window: the top 32 bits of the buffer.
- States:
  - IDLE: cmd_ready=1. Latch all cmd_* fields on cmd_valid, go to DECODE.
  - DECODE: wait while level < 32. When level >= 32, compute the result, register sym_value/sym_len/sym_error, and consume sym_len bits (shift left, level -= sym_len; 0 on error). Go to OUT.
  - OUT: sym_valid=1, outputs held stable. Go to IDLE on sym_ready.
- Latency and throughput: sym_valid rises 2 cycles after the cmd handshake when the buffer is already full. Throughput is 1 symbol per 3 cycles.
- Decode arithmetic (window W, bestcode bc, lz = leading zeros of W over all 32 bits, 0..32):
  - GR path, if W > prefixmask: len = lz+bc+1; value = (lz<<bc) | ((W >> (32-len)) & ((1<<bc)-1)).
  - NGR path, otherwise: len = cwlen; value = codewords + ((W >> (32-cwlen)) & ((1<<suffixlen)-1)).
  - All arithmetic is 32-bit unsigned. sym_value is value[BPC-1:0].
- sym_error=1 in any of these cases; sym_len is then 0, sym_value 0, and the buffer is unchanged:
  - GR path with len > 32.
  - NGR path with cwlen == 0.
  - NGR path with cwlen > 32.
- Simultaneous word accept and consume in the DECODE cycle:
  - Consume first, then append the word at the post-consume level.
  - New level = level - len + 32, never exceeding 64.
- flush has priority over every other event: level=0, state=IDLE, sym_valid=0, any pending command dropped.
- Asynchronous reset mid-symbol discards all state.
- word_data is ignored when word_ready=0.
- cmd_* fields are sampled only on the handshake cycle.

Test Plan:
- GR decode: load 0x3000_0000 then 0x0; cmd bc=2, prefixmask=0x0000_FFFF -> sym_value=10, sym_len=5, sym_error=0; level 64->59.
- NGR decode: window 0x0000_1234; cmd prefixmask=0x0000_FFFF, cwlen=20, suffixlen=4, codewords=100 -> sym_value=101, sym_len=20.
- Starvation: cmd issued with level=0, first word delayed 10 cycles -> sym_valid stays 0 until 2 cycles after level reaches 32; word_ready stays 1 throughout.
- Error: window 0x0000_4000, bc=15, prefixmask=0 (lz=17, len=33) -> sym_error=1, sym_len=0, level unchanged. Repeat with NGR cwlen=0 -> sym_error=1.
- Backpressure and overlap: hold sym_ready=0 for 5 cycles -> outputs stable. Offer a word during the DECODE cycle at level=40 consuming 12 bits -> word not accepted (level>32), level 28 next cycle, then word accepted giving level 60.
- Flush/reset: assert flush in OUT -> sym_valid=0, level=0, cmd_ready=1 next cycle. Drop reset_n asynchronously mid-DECODE -> all outputs reset values immediately.
